// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ranger: trigger pulse, echo timing and direct centimetre accumulation.
// Define RANGER_MEDIAN_EN to publish the median of the last three results.
module ultrasonic_ranger #(
    parameter int CLK_HZ     = 50000000,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_MS  = 60,
    parameter int TIMEOUT_US = 30000
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       enable,
    input  logic       echo,
    output logic       trig,
    output logic [8:0] distance_cm,
    output logic       dist_valid,
    output logic       timeout
);

    localparam int TRIG_CYC = CLK_HZ / 1000000 * TRIG_US;
    localparam int CM_CYC   = CLK_HZ / 1000000 * 58;
    localparam int TO_CYC   = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int PER_CYC  = CLK_HZ / 1000 * PERIOD_MS;
    localparam int CNT_MAX  = (TO_CYC > TRIG_CYC) ? TO_CYC : TRIG_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int SUB_W    = $clog2(CM_CYC + 1);
    localparam int PER_W    = $clog2(PER_CYC + 1);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_CYC - 1);
    localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CM_CYC - 1);
    // GAP leaves two cycles early so the IDLE sample lands exactly PER_CYC after the last start.
    localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PER_CYC - 2);

    typedef enum logic [2:0] {
        ST_IDLE, ST_TRIG, ST_WAIT_RISE, ST_MEASURE, ST_DONE, ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic             echo_meta_q, echo_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [8:0]       cm_q, cm_d;
    logic [PER_W-1:0] per_q, per_d;
    logic             tmo_q, tmo_d;
    logic             trig_q, trig_d;
    logic             dv_q, dv_d;
    logic [8:0]       dist_q, dist_d;
    logic             tout_q, tout_d;
    logic [8:0]       raw;

`ifdef RANGER_MEDIAN_EN
    logic [8:0] hist0_q, hist0_d, hist1_q, hist1_d;
    logic       primed_q, primed_d;

    function automatic logic [8:0] median3(input logic [8:0] a, input logic [8:0] b,
                                           input logic [8:0] c);
        logic [8:0] lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return (c < lo) ? lo : ((c > hi) ? hi : c);
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        per_d   = (state_q == ST_IDLE) ? per_q : per_q + PER_W'(1);
        tmo_d   = tmo_q;
        trig_d  = 1'b0;
        dv_d    = 1'b0;
        dist_d  = dist_q;
        tout_d  = tout_q;
        raw     = tmo_q ? 9'd511 : cm_q;
`ifdef RANGER_MEDIAN_EN
        hist0_d  = hist0_q;
        hist1_d  = hist1_q;
        primed_d = primed_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_TRIG;
                    trig_d  = 1'b1;
                    cnt_d   = '0;
                    per_d   = '0;
                end
            end
            ST_TRIG: begin
                trig_d = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == TRIG_LAST) begin
                    trig_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_WAIT_RISE;
                end
            end
            ST_WAIT_RISE: begin
                // The first high sample already counts toward the echo width.
                if (echo_s_q) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_W'(1);
                    sub_d   = SUB_W'(1);
                    cm_d    = '0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MEASURE: begin
                if (!echo_s_q) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        if (cm_q != 9'd510) cm_d = cm_q + 9'd1;
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
            end
            ST_DONE: begin
                dv_d    = 1'b1;
                state_d = ST_GAP;
`ifdef RANGER_MEDIAN_EN
                hist0_d  = raw;
                hist1_d  = primed_q ? hist0_q : raw;
                dist_d   = primed_q ? median3(raw, hist0_q, hist1_q) : raw;
                primed_d = 1'b1;
                tout_d   = (dist_d == 9'd511);
`else
                dist_d = raw;
                tout_d = tmo_q;
`endif
            end
            ST_GAP: begin
                if (per_q >= PER_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= ST_IDLE;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            cnt_q       <= '0;
            sub_q       <= '0;
            cm_q        <= '0;
            per_q       <= '0;
            tmo_q       <= 1'b0;
            trig_q      <= 1'b0;
            dv_q        <= 1'b0;
            dist_q      <= '0;
            tout_q      <= 1'b0;
`ifdef RANGER_MEDIAN_EN
            hist0_q  <= '0;
            hist1_q  <= '0;
            primed_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            echo_meta_q <= echo;
            echo_s_q    <= echo_meta_q;
            cnt_q       <= cnt_d;
            sub_q       <= sub_d;
            cm_q        <= cm_d;
            per_q       <= per_d;
            tmo_q       <= tmo_d;
            trig_q      <= trig_d;
            dv_q        <= dv_d;
            dist_q      <= dist_d;
            tout_q      <= tout_d;
`ifdef RANGER_MEDIAN_EN
            hist0_q  <= hist0_d;
            hist1_q  <= hist1_d;
            primed_q <= primed_d;
`endif
        end
    end

    assign trig        = trig_q;
    assign distance_cm = dist_q;
    assign dist_valid  = dv_q;
    assign timeout     = tout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger: a per-cycle expected trace built from the measurement
// schedule and latency rules, plus literal result checks.
module tb_ultrasonic_ranger;
    localparam int TRIG_CYC = 10;
    localparam int CM_CYC   = 58;
    localparam int TO_CYC   = 2000;
    localparam int PER_CYC  = 5000;
    localparam int MAXC     = 38001;
`ifdef RANGER_MEDIAN_EN
    localparam bit MED = 1'b1;
`else
    localparam bit MED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, enable, echo;
    logic       trig, dist_valid, timeout;
    logic [8:0] distance_cm;

    ultrasonic_ranger #(
        .CLK_HZ(1000000), .TRIG_US(10), .PERIOD_MS(5), .TIMEOUT_US(2000)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable), .echo(echo),
        .trig(trig), .distance_cm(distance_cm), .dist_valid(dist_valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    bit       exp_trig[MAXC];
    bit       exp_dv[MAXC];
    bit [8:0] exp_dist[MAXC];
    bit       exp_to[MAXC];
    bit [8:0] raws[$];

    function automatic bit [8:0] publish(input bit [8:0] r);
        bit [8:0] w[3];
        bit [8:0] t;
        int n;
        raws.push_back(r);
        if (!MED) return r;
        n = raws.size();
        for (int k = 0; k < 3; k++) w[k] = (n - 1 - k >= 0) ? raws[n-1-k] : raws[0];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2 - i; j++)
                if (w[j] > w[j+1]) begin t = w[j]; w[j] = w[j+1]; w[j+1] = t; end
        return w[1];
    endfunction

    function automatic void m_result(input int d, input bit [8:0] r);
        bit [8:0] p;
        p = publish(r);
        exp_dv[d] = 1'b1;
        for (int i = d; i < MAXC; i++) begin
            exp_dist[i] = p;
            exp_to[i]   = (p == 9'd511);
        end
    endfunction

    function automatic void m_reset(input int c);
        for (int i = c; i < MAXC; i++) begin
            exp_trig[i] = 1'b0; exp_dv[i] = 1'b0; exp_dist[i] = '0; exp_to[i] = 1'b0;
        end
        raws.delete();
    endfunction

    function automatic void m_trig(input int t);
        for (int i = 0; i < TRIG_CYC; i++) exp_trig[t+i] = 1'b1;
    endfunction

    // t: edge after which trig rises; a: edge after which the echo pin rises; h: pin high cycles (0 = no echo)
    function automatic void m_measure(input int t, input int a, input int h);
        int cm;
        m_trig(t);
        cm = h / CM_CYC;
        if (cm > 510) cm = 510;
        if (h == 0)            m_result(t + TRIG_CYC + TO_CYC + 1, 9'd511);
        else if (h >= TO_CYC)  m_result(a + TO_CYC + 3, 9'd511);
        else                   m_result(a + h + 4, 9'(cm));
    endfunction

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic chk_res(input string nm, input int d_raw, input int t_raw,
                           input int d_med, input int t_med);
        chk({nm, "_valid"}, int'(dist_valid), 1);
        chk({nm, "_dist"}, int'(distance_cm), MED ? d_med : d_raw);
        chk({nm, "_timeout"}, int'(timeout), MED ? t_med : t_raw);
    endtask

    task automatic echo_pulse(input int a, input int h);
        at(a); echo = 1'b1;
        at(a + h); echo = 1'b0;
    endtask

    // Per-cycle trace comparison and trig statistics
    int trig_hi = 0;
    int rises[$];
    bit trig_prev = 1'b0;
    initial forever begin
        @(negedge clk);
        if (cyc >= 1 && cyc < MAXC) begin
            n_chk++;
            if ({trig, dist_valid, timeout, distance_cm} ===
                {exp_trig[cyc], exp_dv[cyc], exp_to[cyc], exp_dist[cyc]})
                n_pass++;
            else
                $display("FAIL trace cyc %0d: trig/dv/to/dist got %b/%b/%b/%0d want %b/%b/%b/%0d",
                         cyc, trig, dist_valid, timeout, distance_cm,
                         exp_trig[cyc], exp_dv[cyc], exp_to[cyc], exp_dist[cyc]);
        end
        if (trig === 1'b1) trig_hi++;
        if (trig === 1'b1 && !trig_prev) rises.push_back(cyc);
        trig_prev = (trig === 1'b1);
    end

    initial begin
        m_measure(6, 21, 1000);
        m_measure(5006, 0, 0);
        m_measure(10006, 10019, 57);
        m_measure(15006, 15020, 58);
        m_measure(20006, 20020, 2500);
        m_measure(25006, 25018, 1999);
        m_measure(30006, 30020, 600);
        m_trig(36001);
        m_reset(36004);
        m_trig(36008);
        m_reset(36522);
        m_measure(36526, 36540, 300);

        rst_n = 1'b0; enable = 1'b0; echo = 1'b0;
        at(3);
        chk("rst_trig", int'(trig), 0);
        chk("rst_valid", int'(dist_valid), 0);
        chk("rst_dist", int'(distance_cm), 0);
        chk("rst_timeout", int'(timeout), 0);
        rst_n = 1'b1;
        at(5); enable = 1'b1;

        echo_pulse(21, 1000);
        at(1025); chk_res("m1_1000cyc", 17, 0, 17, 0);
        chk("m1_trig_width", trig_hi, 10);

        at(7017); chk_res("m2_no_echo", 511, 1, 17, 0);

        echo_pulse(10019, 57);
        at(10080); chk_res("m3_57cyc", 0, 0, 17, 0);

        echo_pulse(15020, 58);
        at(15082); chk_res("m4_58cyc", 1, 0, 1, 0);

        at(20020); echo = 1'b1;
        at(22023); chk_res("m5_stuck", 511, 1, 1, 0);
        at(22520); echo = 1'b0;

        echo_pulse(25018, 1999);
        at(27021); chk_res("m6_1999cyc", 34, 0, 34, 0);

        at(30020); echo = 1'b1;
        at(30300); enable = 1'b0;
        at(30620); echo = 1'b0;
        at(30624); chk_res("m7_en_drop", 10, 0, 34, 0);

        at(36000); enable = 1'b1;
        at(36004); rst_n = 1'b0;
        #1;
        chk("rst_in_trig_trig", int'(trig), 0);
        chk("rst_in_trig_dist", int'(distance_cm), 0);
        at(36007); rst_n = 1'b1;

        at(36022); echo = 1'b1;
        at(36522); rst_n = 1'b0; echo = 1'b0;
        #1;
        chk("rst_in_meas_valid", int'(dist_valid), 0);
        at(36525); rst_n = 1'b1;

        echo_pulse(36540, 300);
        at(36844); chk_res("m10_after_rst", 5, 0, 5, 0);
        at(37000); enable = 1'b0;

        at(38000);
        chk("trig_start_count", rises.size(), 10);
        if (rises.size() >= 2) begin
            chk("first_trig_edge", rises[0], 6);
            chk("trig_period", rises[1] - rises[0], PER_CYC);
        end else begin
            chk("trig_rises_seen", rises.size(), 10);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
